// File: rtl/player_motion.sv
// player_motion: per-frame ball physics for the balance board.
// Tilt inputs are integrated into velocity (UPD_V) and then into position
// (UPD_P) once per frame. Collision flags gathered during the frame block
// motion along the flagged direction. Position is held internally as Q11.4.
module player_motion #(
   parameter logic [10:0] START_X   = 11'd320,
   parameter logic [10:0] START_Y   = 11'd240,
   parameter logic [10:0] X_MIN     = 11'd10,
   parameter logic [10:0] X_MAX     = 11'd629,
   parameter logic [10:0] Y_MIN     = 11'd10,
   parameter logic [10:0] Y_MAX     = 11'd469,
   parameter int          ACC_SHIFT = 6,
   parameter logic [15:0] VMAX      = 16'd64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               respawn,
   input  logic signed [10:0] sin_x,
   input  logic signed [10:0] sin_y,
   input  logic [3:0]         collision,
   output logic [10:0]        position_x,
   output logic [10:0]        position_y,
   output logic signed [15:0] vel_x,
   output logic signed [15:0] vel_y,
   output logic               busy,
   output logic               update_done,
   output logic               hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UPD_V = 2'd1,
      UPD_P = 2'd2
   } state_t;

   // Position bounds in Q11.4, widened to 17-bit signed so that an
   // underflowing sum compares as negative instead of wrapping.
   localparam logic signed [16:0] X_LO = $signed({2'b00, X_MIN, 4'b0000});
   localparam logic signed [16:0] X_HI = $signed({2'b00, X_MAX, 4'b0000});
   localparam logic signed [16:0] Y_LO = $signed({2'b00, Y_MIN, 4'b0000});
   localparam logic signed [16:0] Y_HI = $signed({2'b00, Y_MAX, 4'b0000});

   // Tilt to acceleration: sign-extend then arithmetic shift, so negative
   // tilt rounds toward -inf (-1 stays -1).
   function automatic logic signed [16:0] accel(input logic signed [10:0] s);
      logic signed [16:0] ext;
      ext = {{6{s[10]}}, s};
      return ext >>> ACC_SHIFT;
   endfunction

   // Clamp a 17-bit velocity sum into [-VMAX, +VMAX].
   function automatic logic signed [15:0] sat_vel(input logic signed [16:0] v);
      logic signed [16:0] lim;
      logic signed [16:0] nlim;
      lim  = $signed({1'b0, VMAX});
      nlim = -lim;
      if (v > lim)
         return $signed(lim[15:0]);
      else if (v < nlim)
         return $signed(nlim[15:0]);
      else
         return $signed(v[15:0]);
   endfunction

   // True when the velocity points into a blocked direction.
   function automatic logic is_blocked(input logic signed [15:0] v,
                                       input logic pos_blk,
                                       input logic neg_blk);
      return ((v > 16'sd0) && pos_blk) || ((v < 16'sd0) && neg_blk);
   endfunction

   // True when a position sum lies outside [lo, hi].
   function automatic logic out_of_range(input logic signed [16:0] p,
                                         input logic signed [16:0] lo,
                                         input logic signed [16:0] hi);
      return (p < lo) || (p > hi);
   endfunction

   // Limit a position sum to [lo, hi] and return it as unsigned Q11.4.
   function automatic logic [14:0] clamp_pos(input logic signed [16:0] p,
                                             input logic signed [16:0] lo,
                                             input logic signed [16:0] hi);
      logic signed [16:0] r;
      if (p < lo)
         r = lo;
      else if (p > hi)
         r = hi;
      else
         r = p;
      return r[14:0];
   endfunction

   state_t state_q, state_d;

   logic [14:0]        pos_x_q, pos_y_q;
   logic signed [15:0] vel_x_q, vel_y_q;
   logic [3:0]         sticky;
   logic [3:0]         snap_p0;
   logic signed [15:0] vel_x_p1, vel_y_p1;
   logic               blk_x_p1, blk_y_p1;
   logic               done_q, hit_q;

   logic signed [16:0] vsum_x, vsum_y;
   logic signed [15:0] vsat_x, vsat_y;
   logic               blocked_x, blocked_y;
   logic signed [16:0] psum_x, psum_y;

   // State register for the frame update sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic: respawn forces IDLE, ticks outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      if (respawn) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (frame_tick) state_d = UPD_V;
            UPD_V:   state_d = UPD_P;
            UPD_P:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Velocity stage arithmetic: accelerate, saturate, then apply blocking.
   always_comb begin
      vsum_x    = $signed({vel_x_q[15], vel_x_q}) + accel(sin_x);
      vsum_y    = $signed({vel_y_q[15], vel_y_q}) + accel(sin_y);
      vsat_x    = sat_vel(vsum_x);
      vsat_y    = sat_vel(vsum_y);
      blocked_x = is_blocked(vsat_x, snap_p0[0], snap_p0[1]);
      blocked_y = is_blocked(vsat_y, snap_p0[2], snap_p0[3]);
   end

   // Position stage arithmetic: integrate the new velocity, signed 17-bit.
   always_comb begin
      psum_x = $signed({2'b00, pos_x_q}) + $signed({vel_x_p1[15], vel_x_p1});
      psum_y = $signed({2'b00, pos_y_q}) + $signed({vel_y_p1[15], vel_y_p1});
   end

   // Collision accumulation, per-frame snapshot, velocity and position update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_q  <= {START_X, 4'b0000};
         pos_y_q  <= {START_Y, 4'b0000};
         vel_x_q  <= '0;
         vel_y_q  <= '0;
         sticky   <= '0;
         snap_p0  <= '0;
         vel_x_p1 <= '0;
         vel_y_p1 <= '0;
         blk_x_p1 <= 1'b0;
         blk_y_p1 <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
      end else if (respawn) begin
         pos_x_q  <= {START_X, 4'b0000};
         pos_y_q  <= {START_Y, 4'b0000};
         vel_x_q  <= '0;
         vel_y_q  <= '0;
         sticky   <= '0;
         blk_x_p1 <= 1'b0;
         blk_y_p1 <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         done_q <= (state_q == UPD_P);
         hit_q  <= (state_q == UPD_P) && (blk_x_p1 || blk_y_p1);

         // A flag present in the tick cycle belongs to the frame being closed.
         if ((state_q == IDLE) && frame_tick) begin
            snap_p0 <= sticky | collision;
            sticky  <= '0;
         end else begin
            sticky  <= sticky | collision;
         end

         if (state_q == UPD_V) begin
            vel_x_p1 <= blocked_x ? 16'sd0 : vsat_x;
            vel_y_p1 <= blocked_y ? 16'sd0 : vsat_y;
            blk_x_p1 <= blocked_x;
            blk_y_p1 <= blocked_y;
         end

         if (state_q == UPD_P) begin
            pos_x_q <= clamp_pos(psum_x, X_LO, X_HI);
            pos_y_q <= clamp_pos(psum_y, Y_LO, Y_HI);
            vel_x_q <= out_of_range(psum_x, X_LO, X_HI) ? 16'sd0 : vel_x_p1;
            vel_y_q <= out_of_range(psum_y, Y_LO, Y_HI) ? 16'sd0 : vel_y_p1;
         end
      end
   end

   assign position_x  = pos_x_q[14:4];
   assign position_y  = pos_y_q[14:4];
   assign vel_x       = vel_x_q;
   assign vel_y       = vel_y_q;
   assign busy        = (state_q == UPD_V) || (state_q == UPD_P);
   assign update_done = done_q;
   assign hit         = hit_q;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: scoreboard bench for player_motion. Stimulus pushes the
// expected end-of-frame state; a monitor pops and compares on update_done.
module tb_player_motion;

   logic               clk = 1'b0;
   logic               rst;
   logic               frame_tick;
   logic               respawn;
   logic signed [10:0] sin_x, sin_y;
   logic [3:0]         collision;
   logic [10:0]        position_x, position_y;
   logic signed [15:0] vel_x, vel_y;
   logic               busy, update_done, hit;

   typedef struct {
      bit chk;
      int px;
      int py;
      int vx;
      int vy;
      int h;
      int tag;
   } exp_t;

   exp_t q[$];
   int   n_checks   = 0;
   int   n_fail     = 0;
   int   done_count = 0;

   player_motion dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .respawn     (respawn),
      .sin_x       (sin_x),
      .sin_y       (sin_y),
      .collision   (collision),
      .position_x  (position_x),
      .position_y  (position_y),
      .vel_x       (vel_x),
      .vel_y       (vel_y),
      .busy        (busy),
      .update_done (update_done),
      .hit         (hit)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every update_done pops one expected frame result.
   always @(negedge clk) begin
      exp_t e;
      if (update_done === 1'b1) begin
         done_count++;
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_update_done: got pulse at %0t, expected none", $time);
         end else begin
            e = q.pop_front();
            if (e.chk) begin
               check_int($sformatf("f%0d_pos_x", e.tag), int'(position_x), e.px);
               check_int($sformatf("f%0d_pos_y", e.tag), int'(position_y), e.py);
               check_int($sformatf("f%0d_vel_x", e.tag), int'(vel_x), e.vx);
               check_int($sformatf("f%0d_vel_y", e.tag), int'(vel_y), e.vy);
               check_int($sformatf("f%0d_hit", e.tag), int'(hit), e.h);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input bit chk, input int px, input int py,
                               input int vx, input int vy, input int h,
                               input int tag);
      exp_t e;
      e.chk = chk; e.px = px; e.py = py; e.vx = vx; e.vy = vy; e.h = h; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic frame();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      cyc(3);
   endtask

   task automatic do_respawn();
      respawn = 1'b1;
      cyc(1);
      respawn = 1'b0;
   endtask

   task automatic check_home(input string name);
      check_int({name, "_pos_x"}, int'(position_x), 320);
      check_int({name, "_pos_y"}, int'(position_y), 240);
      check_int({name, "_vel_x"}, int'(vel_x), 0);
      check_int({name, "_vel_y"}, int'(vel_y), 0);
      check_int({name, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; frame_tick = 1'b0; respawn = 1'b0;
      sin_x = '0; sin_y = '0; collision = '0;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      check_home("reset");
      check_int("reset_done", int'(update_done), 0);
      check_int("reset_hit", int'(hit), 0);

      // T1: steady tilt of 512 -> accel 8
      sin_x = 11'sd512;
      expect_frame(1, 320, 240, 8, 0, 0, 1);  frame();
      expect_frame(1, 321, 240, 16, 0, 0, 2); frame();

      // T3: +x flag mid-frame blocks the positive velocity
      sin_x = 11'sd0;
      collision = 4'b0001; cyc(1); collision = 4'b0000; cyc(2);
      expect_frame(1, 321, 240, 0, 0, 1, 3); frame();
      expect_frame(1, 321, 240, 0, 0, 0, 4); frame();

      // T2: max tilt saturates at VMAX; sin_y=-1 rounds to -1 per frame
      do_respawn();
      check_home("respawn1");
      sin_x = 11'sd1023; sin_y = -11'sd1;
      expect_frame(1, 320, 239, 15, -1, 0, 5);  frame();
      expect_frame(1, 322, 239, 30, -2, 0, 6);  frame();
      expect_frame(1, 325, 239, 45, -3, 0, 7);  frame();
      expect_frame(1, 329, 239, 60, -4, 0, 8);  frame();
      expect_frame(1, 333, 239, 64, -5, 0, 9);  frame();
      expect_frame(1, 337, 238, 64, -6, 0, 10); frame();
      // -x flag does not block positive motion
      collision = 4'b0010; cyc(1); collision = 4'b0000; cyc(1);
      expect_frame(1, 341, 238, 64, -7, 0, 11); frame();
      // -y flag blocks negative Y motion, X continues
      collision = 4'b1000; cyc(1); collision = 4'b0000; cyc(1);
      expect_frame(1, 345, 238, 64, 0, 1, 12); frame();

      // T4: full negative tilt runs into X_MIN and clamps there
      do_respawn();
      sin_x = -11'sd1024; sin_y = 11'sd0;
      for (int f = 1; f <= 81; f++) begin
         if (f == 3)       expect_frame(1, 314, 240, -48, 0, 0, 13);
         else if (f == 79) expect_frame(1, 10, 240, -64, 0, 0, 14);
         else if (f == 80) expect_frame(1, 10, 240, 0, 0, 0, 15);
         else if (f == 81) expect_frame(1, 10, 240, 0, 0, 0, 16);
         else              expect_frame(0, 0, 0, 0, 0, 0, 0);
         frame();
      end

      // T5: respawn during UPD_V aborts the update
      do_respawn();
      sin_x = 11'sd512;
      expect_frame(1, 320, 240, 8, 0, 0, 20);  frame();
      expect_frame(1, 321, 240, 16, 0, 0, 21); frame();
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check_int("t5_busy_in_upd_v", int'(busy), 1);
      d0 = done_count;
      do_respawn();
      check_home("t5_after_respawn");
      cyc(4);
      check_int("t5_no_done", done_count, d0);
      // respawn coincident with frame_tick: tick dropped
      frame_tick = 1'b1; respawn = 1'b1; cyc(1);
      frame_tick = 1'b0; respawn = 1'b0;
      check_int("t5b_busy", int'(busy), 0);
      cyc(4);
      check_int("t5b_no_done", done_count, d0);
      check_int("t5b_vel_x", int'(vel_x), 0);

      // T6: async reset mid-UPD_P, then a tick in UPD_V is ignored
      expect_frame(1, 320, 240, 8, 0, 0, 30);  frame();
      expect_frame(1, 321, 240, 16, 0, 0, 31); frame();
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_home("t6_async_rst");
      @(negedge clk);
      rst = 1'b0;
      cyc(1);
      d0 = done_count;
      expect_frame(1, 320, 240, 8, 0, 0, 32);
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(6);
      check_int("t6_single_done", done_count, d0 + 1);

      check_int("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
